// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the instruction-ROM port arbiter.
//   rom_port_e : which requester owns a read in flight.
//   rom_tag_t  : per-stage tag {valid, port} carried alongside a ROM read.
package rom_arb_pkg;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DBG   = 1'b1
    } rom_port_e;

    typedef struct packed {
        logic      valid;
        rom_port_e port;
    } rom_tag_t;

    localparam int TAG_W = 2;

    // Wait-counter width; MAX_WAIT = 0 still needs a one-bit register.
    function automatic int count_width(input int max_wait);
        return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
    endfunction

endpackage

// File: rtl/rom_read_tag_pipe.sv
// Delay line of read tags that tracks ROM reads through the ROM latency.
//   clk, rst : clock, async active-high clear (drops every in-flight tag)
//   tag_in   : tag of the read issued this cycle
//   tag_out  : tag of the read whose data is on the ROM output now
module rom_read_tag_pipe
    import rom_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  rom_tag_t tag_in,
    output rom_tag_t tag_out
);

    rom_tag_t stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single synchronous-read ROM port between CPU fetch (high
// priority) and a debug reader (low priority, starvation-protected).
//   i_CLK, i_RST          : clock, async active-high reset
//   i_Fetch_*             : fetch request/address; grant, stall, valid, data
//   i_Dbg_*               : debug request/address (held until granted); grant, valid, data
//   o_Rom_Address         : address driven to the ROM
//   i_Rom_Data            : ROM registered read data
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int MAX_WAIT     = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_Fetch_Req,
    input  logic [ADDR_WIDTH-1:0] i_Fetch_Address,
    output logic                  o_Fetch_Grant,
    output logic                  o_Fetch_Stall,
    output logic                  o_Fetch_Valid,
    output logic [DATA_WIDTH-1:0] o_Fetch_Data,
    input  logic                  i_Dbg_Req,
    input  logic [ADDR_WIDTH-1:0] i_Dbg_Address,
    output logic                  o_Dbg_Grant,
    output logic                  o_Dbg_Valid,
    output logic [DATA_WIDTH-1:0] o_Dbg_Data,
    output logic [ADDR_WIDTH-1:0] o_Rom_Address,
    input  logic [DATA_WIDTH-1:0] i_Rom_Data
);

    localparam int CW = count_width(MAX_WAIT);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] wait_count;
    logic          dbg_win;
    logic          fetch_win;
    rom_tag_t      tag_in;
    rom_tag_t      tag_out;

    // Debug takes the slot when fetch is idle or once it has waited long enough.
    assign dbg_win   = ~i_RST & i_Dbg_Req & ((wait_count == WAIT_MAX) | ~i_Fetch_Req);
    assign fetch_win = ~i_RST & i_Fetch_Req & ~dbg_win;

    assign o_Dbg_Grant   = dbg_win;
    assign o_Fetch_Grant = fetch_win;
    assign o_Fetch_Stall = i_Fetch_Req & ~fetch_win;

    // Idle cycles keep the fetch address on the bus to avoid needless toggling.
    always_comb begin
        o_Rom_Address = i_Fetch_Address;
        if (i_RST)
            o_Rom_Address = '0;
        else if (dbg_win)
            o_Rom_Address = i_Dbg_Address;
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            wait_count <= '0;
        else if (!i_Dbg_Req || dbg_win)
            wait_count <= '0;
        else if (wait_count != WAIT_MAX)
            wait_count <= wait_count + 1'b1;
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = dbg_win | fetch_win;
        tag_in.port  = dbg_win ? PORT_DBG : PORT_FETCH;
    end

    rom_read_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk     (i_CLK),
        .rst     (i_RST),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign o_Fetch_Valid = tag_out.valid & (tag_out.port == PORT_FETCH);
    assign o_Dbg_Valid   = tag_out.valid & (tag_out.port == PORT_DBG);
    assign o_Fetch_Data  = i_Rom_Data;
    assign o_Dbg_Data    = i_Rom_Data;

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // latency-1 instance
    logic        f_req, d_req;
    logic [14:0] f_addr, d_addr, rom_addr;
    logic        f_grant, f_stall, f_valid, d_grant, d_valid;
    logic [15:0] f_data, d_data, rom_data;

    // latency-3 instance
    logic        g_f_req, g_d_req;
    logic [14:0] g_f_addr, g_d_addr, g_rom_addr;
    logic        g_f_grant, g_f_stall, g_f_valid, g_d_grant, g_d_valid;
    logic [15:0] g_f_data, g_d_data, g_rom_data;
    logic [15:0] g_p0, g_p1;

    int n_tests = 0;
    int n_fail  = 0;

    rom_port_arbiter dut (
        .i_CLK(clk), .i_RST(rst),
        .i_Fetch_Req(f_req), .i_Fetch_Address(f_addr),
        .o_Fetch_Grant(f_grant), .o_Fetch_Stall(f_stall),
        .o_Fetch_Valid(f_valid), .o_Fetch_Data(f_data),
        .i_Dbg_Req(d_req), .i_Dbg_Address(d_addr),
        .o_Dbg_Grant(d_grant), .o_Dbg_Valid(d_valid), .o_Dbg_Data(d_data),
        .o_Rom_Address(rom_addr), .i_Rom_Data(rom_data)
    );

    rom_port_arbiter #(.READ_LATENCY(3)) dut3 (
        .i_CLK(clk), .i_RST(rst),
        .i_Fetch_Req(g_f_req), .i_Fetch_Address(g_f_addr),
        .o_Fetch_Grant(g_f_grant), .o_Fetch_Stall(g_f_stall),
        .o_Fetch_Valid(g_f_valid), .o_Fetch_Data(g_f_data),
        .i_Dbg_Req(g_d_req), .i_Dbg_Address(g_d_addr),
        .o_Dbg_Grant(g_d_grant), .o_Dbg_Valid(g_d_valid), .o_Dbg_Data(g_d_data),
        .o_Rom_Address(g_rom_addr), .i_Rom_Data(g_rom_data)
    );

    function automatic logic [15:0] rom_word(input logic [14:0] a);
        case (a)
            15'h0000: return 16'h1234;
            15'h0001: return 16'h5678;
            15'h0002: return 16'h9ABC;
            15'h7FFF: return 16'hBEEF;
            default:  return {a[7:0], ~a[7:0]};
        endcase
    endfunction

    always @(posedge clk) begin
        rom_data   <= rom_word(rom_addr);
        g_p0       <= rom_word(g_rom_addr);
        g_p1       <= g_p0;
        g_rom_data <= g_p1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [14:0] fa, input logic dr, input logic [14:0] da);
        @(negedge clk);
        f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
        #1;
    endtask

    task automatic edge_sample;
        @(posedge clk);
        #1;
    endtask

    initial begin
        f_req = 0; f_addr = 0; d_req = 0; d_addr = 0;
        g_f_req = 0; g_f_addr = 0; g_d_req = 0; g_d_addr = 0;
        rst = 1'b1;

        // reset state, requests present but grants must stay low
        @(negedge clk);
        f_req = 1; f_addr = 15'h0123; d_req = 1; d_addr = 15'h0456;
        #1;
        check("rst_f_grant", f_grant, 0);
        check("rst_d_grant", d_grant, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_f_valid", f_valid, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_count", dut.wait_count, 0);
        @(negedge clk);
        rst = 1'b0;
        f_req = 0; d_req = 0;

        // fetch only
        for (int i = 0; i < 3; i++) begin
            drive(1, 15'(i), 0, 15'h0);
            check("fo_f_grant", f_grant, 1);
            check("fo_rom_addr", rom_addr, i);
            edge_sample();
            check("fo_f_valid", f_valid, 1);
            check("fo_f_data", f_data, (i == 0) ? 16'h1234 : (i == 1) ? 16'h5678 : 16'h9ABC);
            check("fo_d_valid", d_valid, 0);
        end

        // debug only
        drive(0, 15'h0, 1, 15'h7FFF);
        check("do_d_grant", d_grant, 1);
        check("do_f_grant", f_grant, 0);
        check("do_rom_addr", rom_addr, 15'h7FFF);
        edge_sample();
        check("do_d_valid", d_valid, 1);
        check("do_d_data", d_data, 16'hBEEF);
        check("do_f_valid", f_valid, 0);
        check("do_count", dut.wait_count, 0);

        // starvation: debug held from cycle 0, forced win in cycle 8
        for (int c = 0; c <= 8; c++) begin
            drive(1, 15'(16'h0100 + c), 1, 15'h0200);
            check("sv_count", dut.wait_count, c);
            check("sv_d_grant", d_grant, (c == 8));
            check("sv_f_grant", f_grant, (c != 8));
            check("sv_f_stall", f_stall, (c == 8));
            edge_sample();
            check("sv_d_valid", d_valid, (c == 8));
        end
        check("sv_d_data", d_data, rom_word(15'h0200));
        drive(1, 15'h0109, 0, 15'h0);
        check("sv_resume_grant", f_grant, 1);
        check("sv_resume_count", dut.wait_count, 0);
        edge_sample();
        check("sv_resume_valid", f_valid, 1);

        // interleave
        drive(1, 15'h0020, 1, 15'h0030);
        check("il_f_grant", f_grant, 1);
        check("il_d_grant", d_grant, 0);
        edge_sample();
        check("il_f_valid", f_valid, 1);
        check("il_f_data", f_data, rom_word(15'h0020));
        check("il_d_valid0", d_valid, 0);
        drive(0, 15'h0020, 1, 15'h0030);
        check("il_d_grant2", d_grant, 1);
        check("il_rom_addr2", rom_addr, 15'h0030);
        edge_sample();
        check("il_d_valid", d_valid, 1);
        check("il_d_data", d_data, rom_word(15'h0030));
        check("il_f_valid2", f_valid, 0);
        drive(0, 15'h0, 0, 15'h0);
        edge_sample();
        check("il_idle_f", f_valid, 0);
        check("il_idle_d", d_valid, 0);

        // reset mid-read
        drive(1, 15'h0010, 1, 15'h0040);
        check("rm_f_grant", f_grant, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rm_f_grant_rst", f_grant, 0);
        check("rm_d_grant_rst", d_grant, 0);
        check("rm_count", dut.wait_count, 0);
        edge_sample();
        check("rm_f_valid", f_valid, 0);
        check("rm_d_valid", d_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        f_req = 1; f_addr = 15'h0002; d_req = 0;
        #1;
        check("rm_after_grant", f_grant, 1);
        edge_sample();
        check("rm_after_valid", f_valid, 1);
        check("rm_after_data", f_data, 16'h9ABC);
        drive(0, 15'h0, 0, 15'h0);

        // latency-3 instance: fetch, dbg, fetch in cycles 0..2
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            g_f_req = (c == 0) || (c == 2);
            g_f_addr = (c == 2) ? 15'h0002 : 15'h0001;
            g_d_req = (c == 1);
            g_d_addr = 15'h7FFF;
            #1;
            if (c == 1) check("l3_d_grant", g_d_grant, 1);
            edge_sample();
            check("l3_f_valid", g_f_valid, (c == 2) || (c == 4));
            check("l3_d_valid", g_d_valid, (c == 3));
            if (c == 2) check("l3_data0", g_f_data, 16'h5678);
            if (c == 3) check("l3_data1", g_d_data, 16'hBEEF);
            if (c == 4) check("l3_data2", g_f_data, 16'h9ABC);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
